// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared encodings for sized memory accesses. The MEM stage of the CPU decode
// path and data_memory_ctrl both use these, so a request built by the
// decoder can be handed to the memory unchanged.
//   mem_size_e      : access size carried on req_size
//   LANE_MASK_*     : right-aligned byte-lane masks, shifted by the byte
//                     offset to form per-lane write enables
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
    localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
    localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

endpackage

// File: rtl/dm_load_align.sv
// ---------------------------------------------------------------------------
// dm_load_align
// Combinational load alignment: picks the addressed byte or half out of a
// 32-bit memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   word      in  32  raw memory word
//   byte_off  in  2   byte offset within the word (addr[1:0])
//   size      in  2   access size (mem_size_e encoding)
//   zero_ext  in  1   1 = zero-extend, 0 = sign-extend
//   data      out 32  extended load data; 0 for the reserved size
// ---------------------------------------------------------------------------
module dm_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word >> {byte_off, 3'b000});
        lane_h = 16'(word >> {byte_off[1], 4'b0000});
        data   = '0;
        case (mem_size_e'(size))
            SZ_BYTE: data = zero_ext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: data = zero_ext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
// Byte-addressed, word-organised data RAM with sized loads/stores, a
// valid/ready request channel and a fixed-latency, in-order response channel.
// After reset the array is cleared by a one-word-per-cycle init sweep; no
// request is accepted until the sweep finishes.
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   ADDR_W       byte-address width
//   READ_LATENCY accept-to-response latency, 1 or 2
// Ports:
//   clk, reset_n        clock, async active-low reset
//   req_valid/req_ready request handshake (req_ready == init_done)
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        zero-extend loads when 1
//   req_wdata           right-aligned store data
//   rsp_valid           one pulse per accepted request
//   rsp_rdata           extended load data, 0 for stores/errors/idle
//   rsp_err             misaligned, out-of-range or illegal size
//   init_done           init sweep complete
// ---------------------------------------------------------------------------
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e           state, state_next;
    logic [IDX_W-1:0] init_cnt, init_cnt_next;
    logic             init_wr;

    logic [31:0]      mem [DEPTH];

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        init_wr       = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr       = 1'b1;
                init_cnt_next = init_cnt + 1'b1;
                // Last word is cleared on the same edge that enters ST_RUN.
                if (init_cnt == '1)
                    state_next = ST_RUN;
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign init_done = (state == ST_RUN);
    assign req_ready = init_done;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             accept;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic             range_err;
    logic             align_err;
    logic             req_err;
    logic [3:0]       be;
    logic [31:0]      wrep;
    logic             store_en;

    assign accept = req_valid && req_ready;
    assign off    = req_addr[1:0];
    assign idx    = req_addr[IDX_W+1:2];

    // Any address bit above the word-index field means addr >= DEPTH*4.
    if (ADDR_W > IDX_W + 2) begin : g_range
        assign range_err = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign range_err = 1'b0;
    end

    always_comb begin
        align_err = 1'b0;
        be        = '0;
        wrep      = req_wdata;
        case (mem_size_e'(req_size))
            SZ_BYTE: begin
                be   = LANE_MASK_BYTE << off;
                wrep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                align_err = off[0];
                be        = LANE_MASK_HALF << {off[1], 1'b0};
                wrep      = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                align_err = |off;
                be        = LANE_MASK_WORD;
            end
            default: align_err = 1'b1;
        endcase
    end

    assign req_err  = range_err | align_err;
    assign store_en = accept && req_write && !req_err;

    // ------------------------------------------------------------------
    // Storage: sweep and stores never overlap because req_ready is low
    // for the whole sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[init_cnt] <= '0;
        end else if (store_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline stage 1: word captured at the accept edge
    // ------------------------------------------------------------------
    logic        s1_valid;
    logic        s1_err;
    logic        s1_write;
    logic [1:0]  s1_size;
    logic [1:0]  s1_off;
    logic        s1_zext;
    logic [31:0] s1_word;
    logic [31:0] s1_aligned;
    logic [31:0] s1_rdata;
    logic        s1_rsp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_write <= 1'b0;
            s1_size  <= '0;
            s1_off   <= '0;
            s1_zext  <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= accept;
            s1_err   <= req_err;
            s1_write <= req_write;
            s1_size  <= req_size;
            s1_off   <= off;
            s1_zext  <= req_unsigned;
            if (accept)
                s1_word <= mem[idx];
        end
    end

    dm_load_align u_align (
        .word     (s1_word),
        .byte_off (s1_off),
        .size     (s1_size),
        .zero_ext (s1_zext),
        .data     (s1_aligned)
    );

    assign s1_rdata   = (s1_valid && !s1_err && !s1_write) ? s1_aligned : '0;
    assign s1_rsp_err = s1_valid && s1_err;

    // ------------------------------------------------------------------
    // Optional second stage
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic        s2_valid;
        logic        s2_err;
        logic [31:0] s2_rdata;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_rdata <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_rsp_err;
                s2_rdata <= s1_rdata;
            end
        end

        assign rsp_valid = s2_valid;
        assign rsp_err   = s2_err;
        assign rsp_rdata = s2_rdata;
    end else begin : g_lat1
        assign rsp_valid = s1_valid;
        assign rsp_err   = s1_rsp_err;
        assign rsp_rdata = s1_rdata;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed bench for data_memory_ctrl. Two instances share one request
// stream: u_dut1 with READ_LATENCY=1 and u_dut2 with READ_LATENCY=2, so every
// transaction checks both latencies. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        r1_ready, r1_valid, r1_err, r1_done;
    logic [31:0] r1_rdata;
    logic        r2_ready, r2_valid, r2_err, r2_done;
    logic [31:0] r2_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int stray   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH(256), .ADDR_W(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(r1_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err),
        .init_done(r1_done)
    );

    data_memory_ctrl #(.DEPTH(256), .ADDR_W(32), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(r2_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(r2_valid), .rsp_rdata(r2_rdata), .rsp_err(r2_err),
        .init_done(r2_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_size     = W;
        req_unsigned = 1'b0;
        req_wdata    = '0;
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    // One isolated request; both latencies checked. Called at a falling edge.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        drive(wr, addr, size, uns, wdata);
        @(posedge clk);
        @(negedge clk);
        idle();
        check({tag, ".l1.valid"}, r1_valid, 1);
        check({tag, ".l1.rdata"}, r1_rdata, exp_rdata);
        check({tag, ".l1.err"},   r1_err,   exp_err);
        check({tag, ".l2.early"}, r2_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".l1.late"},  r1_valid, 0);
        check({tag, ".l2.valid"}, r2_valid, 1);
        check({tag, ".l2.rdata"}, r2_rdata, exp_rdata);
        check({tag, ".l2.err"},   r2_err,   exp_err);
    endtask

    // Counts edges from reset release until init_done; bounded.
    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        check({tag, ".ready0"}, {r1_ready, r2_ready}, 0);
        while (!r1_done && cyc < 600) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (r1_valid || r2_valid)
                stray++;
        end
        check({tag, ".cycles"}, cyc, 256);
        check({tag, ".done"},   {r1_done, r2_done},   2'b11);
        check({tag, ".ready"},  {r1_ready, r2_ready}, 2'b11);
    endtask

    logic        e1v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] e1d [5] = '{32'h0, 32'h1, 32'hCAFEF00D, 32'h0, 32'h0};
    logic        e2v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e2d [5] = '{32'h0, 32'h0, 32'h1, 32'hCAFEF00D, 32'h0};

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.valid", {r1_valid, r2_valid}, 0);
        check("rst.rdata", r1_rdata | r2_rdata, 0);
        check("rst.err",   {r1_err, r2_err}, 0);
        check("rst.done",  {r1_done, r2_done}, 0);
        check("rst.ready", {r1_ready, r2_ready}, 0);
        reset_n = 1'b1;
        wait_init("init");

        // Sweep cleared the last word
        do_req("ld3fc", 0, 32'h3FC, W, 0, 0, 32'h0, 0);

        // Sized loads with extension
        do_req("st10",   1, 32'h10, W, 0, 32'hDEADBEEF, 32'h0, 0);
        do_req("ld13bs", 0, 32'h13, B, 0, 0, 32'hFFFFFFDE, 0);
        do_req("ld13bu", 0, 32'h13, B, 1, 0, 32'h000000DE, 0);
        do_req("ld10hs", 0, 32'h10, H, 0, 0, 32'hFFFFBEEF, 0);
        do_req("ld12hu", 0, 32'h12, H, 1, 0, 32'h0000DEAD, 0);
        do_req("ld11bs", 0, 32'h11, B, 0, 0, 32'hFFFFFFBE, 0);

        // Byte-lane merge; upper wdata bits must be ignored
        do_req("st20",   1, 32'h20, W, 0, 32'h11223344, 32'h0, 0);
        do_req("st21b",  1, 32'h21, B, 0, 32'hABCDEF5A, 32'h0, 0);
        do_req("ld20a",  0, 32'h20, W, 0, 0, 32'h11225A44, 0);

        // Errors
        do_req("st22w",  1, 32'h22, W, 0, 32'hFFFFFFFF, 32'h0, 1);
        do_req("ld20b",  0, 32'h20, W, 0, 0, 32'h11225A44, 0);
        do_req("ld21h",  0, 32'h21, H, 0, 0, 32'h0, 1);
        do_req("ld400",  0, 32'h400, W, 0, 0, 32'h0, 1);
        do_req("ld400b", 0, 32'h400, B, 1, 0, 32'h0, 1);
        do_req("ldsz3",  0, 32'h20, X, 0, 0, 32'h0, 1);
        do_req("st_far", 1, 32'h80000020, W, 0, 32'h0, 32'h0, 1);
        do_req("ld20c",  0, 32'h20, W, 0, 0, 32'h11225A44, 0);

        // Upper half store and top-of-memory byte
        do_req("st22h",  1, 32'h22, H, 0, 32'h00009876, 32'h0, 0);
        do_req("ld20d",  0, 32'h20, W, 0, 0, 32'h98765A44, 0);
        do_req("st3ffb", 1, 32'h3FF, B, 0, 32'h00000077, 32'h0, 0);
        do_req("ld3ffb", 0, 32'h3FF, B, 1, 0, 32'h00000077, 0);
        do_req("st44",   1, 32'h44, W, 0, 32'hCAFEF00D, 32'h0, 0);

        // Back-to-back: store 0x40, load 0x40, load 0x44 on consecutive edges
        drive(1, 32'h40, W, 0, 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0)      drive(0, 32'h40, W, 0, 0);
            else if (k == 1) drive(0, 32'h44, W, 0, 0);
            else             idle();
            check($sformatf("b2b.l1.valid%0d", k), r1_valid, e1v[k]);
            check($sformatf("b2b.l1.rdata%0d", k), r1_rdata, e1d[k]);
            check($sformatf("b2b.l2.valid%0d", k), r2_valid, e2v[k]);
            check($sformatf("b2b.l2.rdata%0d", k), r2_rdata, e2d[k]);
            check($sformatf("b2b.err%0d", k), {r1_err, r2_err}, 0);
        end

        // Reset with loads in flight
        drive(0, 32'h10, W, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 32'h44, W, 0, 0);
        check("mid.l1.first", r1_rdata, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        idle();
        check("mid.l2.first", r2_rdata, 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        check("mid.drop.valid", {r1_valid, r2_valid}, 0);
        check("mid.drop.rdata", r1_rdata | r2_rdata, 0);
        stray = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (r1_valid || r2_valid)
                stray++;
        end
        reset_n = 1'b1;
        wait_init("midstream");
        check("midstream.stray", stray, 0);
        do_req("ld10clr", 0, 32'h10, W, 0, 0, 32'h0, 0);

        // Reset in the middle of the sweep restarts it
        do_req("st50", 1, 32'h50, W, 0, 32'h55AA55AA, 32'h0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("sweep100.done", {r1_done, r2_done}, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("sweep100.rst", {r1_done, r1_ready}, 0);
        reset_n = 1'b1;
        wait_init("resweep");
        do_req("ld50clr", 0, 32'h50, W, 0, 0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
